// File: rtl/tpu_sram_pkg.sv
// Shared definitions for the HPS SRAM DMA master: FSM states, command word layout
// and the transfer-direction encodings.
package tpu_sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_DRAIN,
        ST_WR,
        ST_DONE
    } state_t;

    localparam int CMD_START    = 31;
    localparam int CMD_DIR      = 30;
    localparam int CMD_LEN_MSB  = 23;
    localparam int CMD_LEN_LSB  = 12;
    localparam int CMD_BASE_MSB = 11;
    localparam int CMD_BASE_LSB = 0;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    // One extra bit so a full 4096-word length is representable.
    localparam int LEN_W = CMD_LEN_MSB - CMD_LEN_LSB + 2;

    function automatic logic [LEN_W-1:0] cmd_len(input logic [31:0] cmd);
        return {1'b0, cmd[CMD_LEN_MSB:CMD_LEN_LSB]} + LEN_W'(1);
    endfunction

endpackage

// File: rtl/sram_rd_fifo.sv
// Small synchronous show-ahead FIFO: the head entry is visible on o_dout whenever
// o_empty is low, and a pop simply advances to the next entry.
module sram_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
)(
    input  logic                     clk,
    input  logic                     i_srst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~w_full | w_pop);
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/hps_sram_dma_master.sv
// Command-driven block mover between the HPS on-chip SRAM s1 port and the TPU
// datapath streams, with a four-phase done handshake back to the HPS.
module hps_sram_dma_master
    import tpu_sram_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ctrl_cmd,
    output logic              ctrl_done,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_address,
    output logic              sram_clken,
    output logic              sram_chipselect,
    output logic              sram_write,
    output logic [DATA_W-1:0] sram_writedata,
    output logic [3:0]        sram_byteenable,
    input  logic [DATA_W-1:0] sram_readdata,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_beat;
    logic              r_cs;
    logic              r_we;
    logic              r_clken;
    logic              r_done;
    logic              r_s_ready;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_be;
    logic [CW-1:0]     r_inflight;
    logic              r_rvalid [RD_LATENCY];

    logic [CW-1:0]     w_fifo_count;
    logic [DATA_W-1:0] w_fifo_dout;
    logic              w_fifo_empty;
    logic [CW:0]       w_credit;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_wr_beat;
    logic              w_last_xfer;
    logic              w_drain_done;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_unused_cmd;

    assign w_unused_cmd = ^ctrl_cmd[CMD_DIR-1:CMD_LEN_MSB+1];

    // Credit covers both words already in the FIFO and reads still in the SRAM
    // pipeline, so a return always finds a free FIFO slot.
    assign w_credit     = {1'b0, w_fifo_count} + {1'b0, r_inflight};
    assign w_issue      = (r_state == ST_RD) && (w_credit < (CW+1)'(FIFO_DEPTH));
    assign w_push       = r_rvalid[RD_LATENCY-1];
    assign w_pop        = ~w_fifo_empty & m_ready;
    assign w_wr_beat    = (r_state == ST_WR) & s_valid & r_s_ready;
    assign w_last_xfer  = (r_cnt == r_len - LEN_W'(1));
    assign w_next_addr  = r_base + ADDR_W'(r_cnt);
    assign w_drain_done = (r_inflight == '0) &&
                          (w_fifo_empty || ((w_fifo_count == CW'(1)) && w_pop));

    assign sram_address    = r_addr;
    assign sram_clken      = r_clken;
    assign sram_chipselect = r_cs;
    assign sram_write      = r_we;
    assign sram_writedata  = r_wdata;
    assign sram_byteenable = r_be;
    assign ctrl_done       = r_done;
    assign busy            = (r_state != ST_IDLE);
    assign s_ready         = r_s_ready;
    assign m_valid         = ~w_fifo_empty;
    assign m_data          = w_fifo_empty ? '0 : w_fifo_dout;
    assign m_last          = ~w_fifo_empty && (r_beat == r_len - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_base    <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_beat    <= '0;
            r_cs      <= 1'b0;
            r_we      <= 1'b0;
            r_clken   <= 1'b0;
            r_done    <= 1'b0;
            r_s_ready <= 1'b0;
            r_wdata   <= '0;
            r_be      <= '0;
        end else begin
            r_clken <= 1'b1;
            r_cs    <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (ctrl_cmd[CMD_START]) begin
                        r_base <= ADDR_W'(ctrl_cmd[CMD_BASE_MSB:CMD_BASE_LSB]);
                        r_len  <= cmd_len(ctrl_cmd);
                        r_cnt  <= '0;
                        r_beat <= '0;
                        if (ctrl_cmd[CMD_DIR] == DIR_WRITE) begin
                            r_state   <= ST_WR;
                            r_s_ready <= 1'b1;
                        end else begin
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (w_issue) begin
                        r_cs   <= 1'b1;
                        r_addr <= w_next_addr;
                        r_cnt  <= r_cnt + LEN_W'(1);
                        if (w_last_xfer) r_state <= ST_RD_DRAIN;
                    end
                end
                ST_RD_DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (w_wr_beat) begin
                        r_cs    <= 1'b1;
                        r_we    <= 1'b1;
                        r_be    <= 4'hF;
                        r_addr  <= w_next_addr;
                        r_wdata <= s_data;
                        r_cnt   <= r_cnt + LEN_W'(1);
                        if (w_last_xfer) begin
                            r_s_ready <= 1'b0;
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!ctrl_cmd[CMD_START]) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_pop) r_beat <= r_beat + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
        end
    end

    // Read-valid pipeline matching the SRAM read latency; stage 0 tracks a read on the bus.
    always_ff @(posedge clk) begin
        if (reset) r_rvalid[0] <= 1'b0;
        else       r_rvalid[0] <= r_cs & ~r_we;
    end

    generate
        for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_rvalid
            always_ff @(posedge clk) begin
                if (reset) r_rvalid[gi] <= 1'b0;
                else       r_rvalid[gi] <= r_rvalid[gi-1];
            end
        end
    endgenerate

    sram_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_rd_fifo (
        .clk     (clk),
        .i_srst  (reset),
        .i_push  (w_push),
        .i_din   (sram_readdata),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

endmodule

// File: tb/tb_hps_sram_dma_master.sv
// Randomized bench for hps_sram_dma_master: SRAM model, stream drivers and a
// queue-based reference of expected beats and writes.
module tb_hps_sram_dma_master;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 32;
    localparam int RD_LATENCY = 1;
    localparam int FIFO_DEPTH = 4;

    logic              clk;
    logic              reset;
    logic [31:0]       ctrl_cmd;
    logic              ctrl_done;
    logic              busy;
    logic [ADDR_W-1:0] sram_address;
    logic              sram_clken;
    logic              sram_chipselect;
    logic              sram_write;
    logic [DATA_W-1:0] sram_writedata;
    logic [3:0]        sram_byteenable;
    logic [DATA_W-1:0] sram_readdata;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    hps_sram_dma_master #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LATENCY (RD_LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ctrl_cmd        (ctrl_cmd),
        .ctrl_done       (ctrl_done),
        .busy            (busy),
        .sram_address    (sram_address),
        .sram_clken      (sram_clken),
        .sram_chipselect (sram_chipselect),
        .sram_write      (sram_write),
        .sram_writedata  (sram_writedata),
        .sram_byteenable (sram_byteenable),
        .sram_readdata   (sram_readdata),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_last          (m_last),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // SRAM s1 model, one cycle read latency
    logic [31:0] mem [4096];
    logic [31:0] rd_q;
    assign sram_readdata = rd_q;
    always @(posedge clk) begin
        if (sram_clken && sram_chipselect) begin
            if (sram_write) mem[sram_address] = sram_writedata;
            else            rd_q <= mem[sram_address];
        end
    end

    typedef struct packed { logic [31:0] d; logic last; } rd_exp_t;
    typedef struct packed { logic [11:0] a; logic [31:0] d; } wr_exp_t;
    rd_exp_t exp_rd_q[$];
    wr_exp_t exp_wr_q[$];

    bit          rd_active = 0;
    bit          wr_drive  = 0;
    int          rdy_mode  = 0;
    logic [11:0] rd_addr_exp = '0;
    logic [11:0] last_rd_addr = '0;
    logic [11:0] wr_base = '0;
    int          beat_cnt = 0;
    int          rd_issue_cnt = 0;
    int          wr_idx = 0;
    int          wr_len = 0;
    int          access_cnt = 0;
    int          cyc = 0;
    int          last_rd_cyc = 0;

    // Output monitor: sampled on the falling edge, away from the DUT's active edge
    always @(negedge clk) begin
        rd_exp_t re;
        wr_exp_t we;
        cyc++;
        if (!reset) begin
            if (sram_chipselect) access_cnt++;
            if (m_valid && m_ready) begin
                if (exp_rd_q.size() == 0) begin
                    check_eq("extra_beat", 64'(exp_rd_q.size()), 64'd1);
                end else begin
                    re = exp_rd_q.pop_front();
                    check_eq("m_data", 64'(m_data), 64'(re.d));
                    check_eq("m_last", 64'(m_last), 64'(re.last));
                end
                beat_cnt++;
            end
            if (sram_chipselect && !sram_write) begin
                check_eq("rd_expected", 64'(rd_active), 64'd1);
                check_eq("rd_addr", 64'(sram_address), 64'(rd_addr_exp));
                if (rdy_mode == 0 && rd_issue_cnt > 0)
                    check_eq("rd_back_to_back", 64'(cyc - last_rd_cyc), 64'd1);
                last_rd_addr = rd_addr_exp;
                last_rd_cyc  = cyc;
                rd_addr_exp++;
                rd_issue_cnt++;
            end else if (rd_active && rd_issue_cnt > 0 && !sram_chipselect) begin
                check_eq("rd_addr_hold", 64'(sram_address), 64'(last_rd_addr));
            end
            if (sram_chipselect && sram_write) begin
                check_eq("wr_byteen", 64'(sram_byteenable), 64'hF);
                if (exp_wr_q.size() == 0) begin
                    check_eq("wr_unexpected", 64'(exp_wr_q.size()), 64'd1);
                end else begin
                    we = exp_wr_q.pop_front();
                    check_eq("wr_addr", 64'(sram_address), 64'(we.a));
                    check_eq("wr_data", 64'(sram_writedata), 64'(we.d));
                end
            end
            if (s_valid && s_ready) begin
                check_eq("s_hs_in_range", 64'(wr_idx < wr_len), 64'd1);
                exp_wr_q.push_back('{a: wr_base + 12'(wr_idx), d: s_data});
                wr_idx++;
            end
        end
    end

    // m_ready driver: 0 = always ready, 1 = random, 2 = one 10-cycle stall after beat 3
    initial begin
        int  stall_left;
        bit  stall_used;
        stall_left = 0;
        stall_used = 0;
        m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode != 2) stall_used = 0;
            if (rdy_mode == 0) begin
                m_ready = 1'b1;
            end else if (rdy_mode == 1) begin
                m_ready = ($urandom_range(0, 3) != 0);
            end else begin
                if (!stall_used && beat_cnt >= 3) begin
                    stall_left = 10;
                    stall_used = 1;
                end
                if (stall_left > 0) begin
                    m_ready = 1'b0;
                    stall_left--;
                    if (stall_left == 0)
                        check_eq("stall_credit", 64'(rd_issue_cnt - beat_cnt), 64'(FIFO_DEPTH));
                end else begin
                    m_ready = 1'b1;
                end
            end
        end
    end

    // Gapped write-stream source
    initial begin
        s_valid = 1'b0;
        s_data  = '0;
        forever begin
            @(posedge clk); #1;
            s_data  = $urandom;
            s_valid = wr_drive ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!ctrl_done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("done_timeout", 64'(ctrl_done), 64'd1);
    endtask

    task automatic check_outputs_zero();
        check_eq("z_addr",  64'(sram_address), 64'd0);
        check_eq("z_clken", 64'(sram_clken), 64'd0);
        check_eq("z_cs",    64'(sram_chipselect), 64'd0);
        check_eq("z_we",    64'(sram_write), 64'd0);
        check_eq("z_wdata", 64'(sram_writedata), 64'd0);
        check_eq("z_be",    64'(sram_byteenable), 64'd0);
        check_eq("z_mdata", 64'(m_data), 64'd0);
        check_eq("z_mvalid",64'(m_valid), 64'd0);
        check_eq("z_mlast", 64'(m_last), 64'd0);
        check_eq("z_sready",64'(s_ready), 64'd0);
        check_eq("z_done",  64'(ctrl_done), 64'd0);
        check_eq("z_busy",  64'(busy), 64'd0);
    endtask

    task automatic setup_read(input logic [11:0] base, input int len);
        logic [11:0] a;
        exp_rd_q.delete();
        for (int i = 0; i < len; i++) begin
            a = base + 12'(i);
            exp_rd_q.push_back('{d: mem[a], last: (i == len - 1)});
        end
        rd_addr_exp  = base;
        beat_cnt     = 0;
        rd_issue_cnt = 0;
        rd_active    = 1;
    endtask

    task automatic run_xfer(input bit dir, input logic [11:0] base, input logic [11:0] lenm1,
                            input int rmode, input bit drop_start, input int hold);
        int          len;
        int          snap;
        logic [31:0] cmd;
        len = int'(lenm1) + 1;
        $display("[TB] xfer %s base=0x%03h len=%0d ready_mode=%0d drop=%0d hold=%0d",
                 dir ? "WRITE" : "READ ", base, len, rmode, drop_start, hold);
        if (!dir) begin
            setup_read(base, len);
            rdy_mode = rmode;
        end else begin
            exp_wr_q.delete();
            wr_base  = base;
            wr_idx   = 0;
            wr_len   = len;
            wr_drive = 1;
        end
        cmd         = $urandom;
        cmd[31]     = 1'b1;
        cmd[30]     = dir;
        cmd[23:12]  = lenm1;
        cmd[11:0]   = base;
        ctrl_cmd    = cmd;
        @(posedge clk); #1;
        check_eq("busy_after_start", 64'(busy), 64'd1);
        // Scramble non-START fields: they must be ignored once the transfer is running
        cmd[23:0] = 24'($urandom);
        cmd[30]   = ~dir;
        if (drop_start) cmd[31] = 1'b0;
        ctrl_cmd  = cmd;
        wait_done(len * 8 + 100);
        check_eq("s_ready_in_done", 64'(s_ready), 64'd0);
        check_eq("busy_in_done", 64'(busy), 64'd1);
        @(posedge clk); #1;
        if (!dir) begin
            check_eq("rd_beats", 64'(beat_cnt), 64'(len));
            check_eq("rd_issued", 64'(rd_issue_cnt), 64'(len));
            check_eq("rd_left", 64'(exp_rd_q.size()), 64'd0);
        end else begin
            check_eq("wr_beats", 64'(wr_idx), 64'(len));
            check_eq("wr_left", 64'(exp_wr_q.size()), 64'd0);
        end
        if (!drop_start) begin
            snap = access_cnt;
            repeat (hold) begin
                check_eq("done_held", 64'(ctrl_done), 64'd1);
                @(posedge clk); #1;
            end
            check_eq("no_access_in_done", 64'(access_cnt), 64'(snap));
            cmd[31]  = 1'b0;
            ctrl_cmd = cmd;
            @(posedge clk); #1;
        end
        check_eq("done_fall", 64'(ctrl_done), 64'd0);
        check_eq("idle", 64'(busy), 64'd0);
        rd_active = 0;
        wr_drive  = 0;
        rdy_mode  = 0;
    endtask

    task automatic reset_mid_read();
        logic [11:0] base;
        int          n;
        int          snap;
        base = 12'($urandom);
        $display("[TB] xfer READ  base=0x%03h len=8 with reset during beat 3", base);
        setup_read(base, 8);
        rdy_mode = 0;
        ctrl_cmd = {1'b1, 1'b0, 6'd0, 12'd7, base};
        n = 0;
        while (beat_cnt < 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("rst_reach_beat3", 64'(beat_cnt >= 2), 64'd1);
        reset    = 1'b1;
        ctrl_cmd = '0;
        @(posedge clk); #1;
        reset     = 1'b0;
        rd_active = 0;
        exp_rd_q.delete();
        check_outputs_zero();
        snap = access_cnt;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rst_no_access", 64'(access_cnt), 64'(snap));
        check_eq("rst_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        ctrl_cmd = '0;
        for (int a = 0; a < 4096; a++) mem[a] = 32'(a) + 32'hA0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero();
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("clken_after_reset", 64'(sram_clken), 64'd1);
        check_eq("idle_after_reset", 64'(busy), 64'd0);

        run_xfer(1'b0, 12'h010, 12'd3, 0, 1'b0, 3);
        run_xfer(1'b0, 12'($urandom), 12'd7, 2, 1'b0, 2);
        run_xfer(1'b1, 12'hFFE, 12'd2, 0, 1'b0, 2);
        run_xfer(1'b0, 12'hFFE, 12'd2, 1, 1'b0, 1);
        reset_mid_read();
        run_xfer(1'b0, 12'($urandom), 12'd1, 0, 1'b0, 1);
        run_xfer(1'b0, 12'($urandom), 12'd0, 0, 1'b0, 1);
        run_xfer(1'b1, 12'($urandom), 12'd0, 0, 1'b0, 1);
        run_xfer(1'b0, 12'($urandom), 12'hFFF, 1, 1'b0, 1);
        run_xfer(1'b0, 12'($urandom), 12'd9, 1, 1'b1, 0);
        run_xfer(1'b1, 12'($urandom), 12'd5, 0, 1'b1, 0);
        run_xfer(1'b0, 12'($urandom), 12'd3, 0, 1'b0, 20);
        for (int t = 0; t < 8; t++) begin
            run_xfer(1'($urandom_range(0, 1)), 12'($urandom), 12'($urandom_range(0, 31)),
                     $urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom_range(1, 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
